// File: rtl/ccip_mmio_csr.sv
// ccip_mmio_csr: CCI-P MMIO CSR responder for the AFU clock domain.
// Decodes MMIO requests from Rx c0, holds the DFH/ID/control/status registers,
// and returns read responses on Tx c2 with a fixed two-cycle latency.
//
// Optional build macro: MMIO_CSR_STATS_EN adds RD_COUNT (0x0028), WR_COUNT
// (0x002A) and a counter-clear strobe register (0x002C).
//
// Flattened CCI-P port layouts (only the fields this block uses):
//   cp2af_sRxPort[93]    c0 mmioRdValid
//   cp2af_sRxPort[92]    c0 mmioWrValid
//   cp2af_sRxPort[91:64] c0 hdr: address[15:0] @91:76, length[1:0] @75:74,
//                        rsvd @73, tid[8:0] @72:64
//   cp2af_sRxPort[63:0]  c0 data[63:0]
//   af2cp_sTxC2[73]      mmioRdValid
//   af2cp_sTxC2[72:64]   hdr.tid
//   af2cp_sTxC2[63:0]    data
module ccip_mmio_csr #(
    parameter logic [63:0] AFU_DFH  = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter logic [63:0] AFU_ID_H = 64'h0
) (
    input  logic        Clk_400,
    input  logic        SoftReset,
    input  logic [93:0] cp2af_sRxPort,
    output logic [73:0] af2cp_sTxC2,
    output logic [63:0] csr_ctl,
    output logic        csr_go,
    input  logic [63:0] csr_status,
    output logic        mmio_err
);

    // 64-bit register index = word address >> 1
    localparam logic [14:0] IDX_DFH     = 15'h0000;
    localparam logic [14:0] IDX_ID_L    = 15'h0001;
    localparam logic [14:0] IDX_ID_H    = 15'h0002;
    localparam logic [14:0] IDX_SCRATCH = 15'h0010;
    localparam logic [14:0] IDX_CTL     = 15'h0011;
    localparam logic [14:0] IDX_STATUS  = 15'h0012;
    localparam logic [14:0] IDX_CYCLES  = 15'h0013;
`ifdef MMIO_CSR_STATS_EN
    localparam logic [14:0] IDX_RD_CNT  = 15'h0014;
    localparam logic [14:0] IDX_WR_CNT  = 15'h0015;
    localparam logic [14:0] IDX_CNT_CLR = 15'h0016;
`endif

    // A 4 B write replaces only the addressed half; an 8 B write replaces all.
    function automatic logic [63:0] merge_wdata(input logic [63:0] old,
                                                input logic [63:0] wdata,
                                                input logic        len8,
                                                input logic        half);
        if (len8)
            return wdata;
        else if (half)
            return {wdata[31:0], old[31:0]};
        else
            return {old[63:32], wdata[31:0]};
    endfunction

    // A 4 B read returns the addressed half in the low word; errors read 0.
    function automatic logic [63:0] shape_rdata(input logic [63:0] sel,
                                                input logic        len8,
                                                input logic        half,
                                                input logic        bad);
        if (bad)
            return 64'h0;
        else if (len8)
            return sel;
        else
            return {32'h0, half ? sel[63:32] : sel[31:0]};
    endfunction

    logic        rd_vld_p0, wr_vld_p0;
    logic [15:0] addr_p0;
    logic [1:0]  len_p0;
    logic [8:0]  tid_p0;
    logic [63:0] wdata_p0;
    logic [14:0] idx_p0;
    logic        len8_p0, bad_p0, rd_acc_p0, wr_en_p0, err_p0;
    logic        unused_rsvd;

    assign rd_vld_p0   = cp2af_sRxPort[93];
    assign wr_vld_p0   = cp2af_sRxPort[92];
    assign addr_p0     = cp2af_sRxPort[91:76];
    assign len_p0      = cp2af_sRxPort[75:74];
    assign unused_rsvd = cp2af_sRxPort[73];
    assign tid_p0      = cp2af_sRxPort[72:64];
    assign wdata_p0    = cp2af_sRxPort[63:0];

    assign idx_p0    = addr_p0[15:1];
    assign len8_p0   = (len_p0 == 2'd1);
    // Lengths above 8 B and misaligned 8 B accesses are protocol errors.
    assign bad_p0    = (len_p0 > 2'd1) || (len8_p0 && addr_p0[0]);
    // A read colliding with a write is dropped; the write still executes.
    assign rd_acc_p0 = rd_vld_p0 && !wr_vld_p0;
    assign wr_en_p0  = wr_vld_p0 && !bad_p0;
    assign err_p0    = ((rd_vld_p0 || wr_vld_p0) && bad_p0) || (rd_vld_p0 && wr_vld_p0);

    logic [63:0] scratch;
    logic [63:0] cycles;
`ifdef MMIO_CSR_STATS_EN
    logic [63:0] rd_count;
    logic [63:0] wr_count;
`endif

    // Register writes, GO pulse, sticky error flag and free-running cycle counter.
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            scratch  <= 64'h0;
            csr_ctl  <= 64'h0;
            csr_go   <= 1'b0;
            mmio_err <= 1'b0;
            cycles   <= 64'h0;
        end else begin
            cycles <= cycles + 64'd1;
            csr_go <= wr_en_p0 && (idx_p0 == IDX_CTL) && !addr_p0[0] && wdata_p0[0];
            if (wr_en_p0 && (idx_p0 == IDX_SCRATCH))
                scratch <= merge_wdata(scratch, wdata_p0, len8_p0, addr_p0[0]);
            if (wr_en_p0 && (idx_p0 == IDX_CTL))
                csr_ctl <= merge_wdata(csr_ctl, wdata_p0, len8_p0, addr_p0[0]) & ~64'd1;
            if (err_p0)
                mmio_err <= 1'b1;
        end
    end

`ifdef MMIO_CSR_STATS_EN
    // Access statistics; a write to the clear register zeroes both counts.
    always_ff @(posedge Clk_400) begin
        if (SoftReset || (wr_en_p0 && (idx_p0 == IDX_CNT_CLR))) begin
            rd_count <= 64'h0;
            wr_count <= 64'h0;
        end else begin
            if (rd_acc_p0)
                rd_count <= rd_count + 64'd1;
            if (wr_en_p0)
                wr_count <= wr_count + 64'd1;
        end
    end
`endif

    logic        vld_p1;
    logic [8:0]  tid_p1;
    logic [14:0] idx_p1;
    logic        half_p1, len8_p1, bad_p1;

    // Read stage 1: capture the accepted request; only the valid bit is reset.
    always_ff @(posedge Clk_400) begin
        if (SoftReset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_acc_p0;
        tid_p1  <= tid_p0;
        idx_p1  <= idx_p0;
        half_p1 <= addr_p0[0];
        len8_p1 <= len8_p0;
        bad_p1  <= bad_p0;
    end

    logic [63:0] sel_p1;
    logic [63:0] rdata_p1;

    // Register selection; STATUS and CYCLES are sampled in this stage.
    always_comb begin
        sel_p1 = 64'h0;
        case (idx_p1)
            IDX_DFH:     sel_p1 = AFU_DFH;
            IDX_ID_L:    sel_p1 = AFU_ID_L;
            IDX_ID_H:    sel_p1 = AFU_ID_H;
            IDX_SCRATCH: sel_p1 = scratch;
            IDX_CTL:     sel_p1 = csr_ctl;
            IDX_STATUS:  sel_p1 = csr_status;
            IDX_CYCLES:  sel_p1 = cycles;
`ifdef MMIO_CSR_STATS_EN
            IDX_RD_CNT:  sel_p1 = rd_count;
            IDX_WR_CNT:  sel_p1 = wr_count;
`endif
            default:     sel_p1 = 64'h0;
        endcase
    end

    assign rdata_p1 = shape_rdata(sel_p1, len8_p1, half_p1, bad_p1);

    // Read stage 2: registered response; tid and data held at 0 when idle.
    always_ff @(posedge Clk_400) begin
        if (SoftReset || !vld_p1)
            af2cp_sTxC2 <= 74'h0;
        else
            af2cp_sTxC2 <= {1'b1, tid_p1, rdata_p1};
    end

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// tb_ccip_mmio_csr: scoreboard bench for the MMIO CSR responder.
module tb_ccip_mmio_csr;

    localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
    localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [93:0] rx  = '0;
    logic [73:0] tx;
    logic [63:0] ctl;
    logic        go;
    logic [63:0] status = '0;
    logic        err;

    always #5 clk = ~clk;

    ccip_mmio_csr #(.AFU_DFH(DFH), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
        .Clk_400      (clk),
        .SoftReset    (rst),
        .cp2af_sRxPort(rx),
        .af2cp_sTxC2  (tx),
        .csr_ctl      (ctl),
        .csr_go       (go),
        .csr_status   (status),
        .mmio_err     (err)
    );

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
        bit          chk;
    } exp_t;

    exp_t        q[$];
    logic [63:0] cap[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [93:0] pk(input bit rd, input bit wr, input logic [15:0] a,
                                       input logic [1:0] l, input logic [8:0] t,
                                       input logic [63:0] d);
        return {rd, wr, a, l, 1'b0, t, d};
    endfunction

    // Response monitor: every response must match the scoreboard head at its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx[73] === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected got tid=%h data=%h required=none", tx[72:64], tx[63:0]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (tx[72:64] !== e.tid || cyc != e.due || (e.chk && tx[63:0] !== e.data)) begin
                        bad++;
                        $display("FAIL rsp got tid=%h data=%h cyc=%0d required tid=%h data=%h cyc=%0d",
                                 tx[72:64], tx[63:0], cyc, e.tid, e.data, e.due);
                    end
                    if (!e.chk) cap.push_back(tx[63:0]);
                end
            end else begin
                total++;
                if (tx !== 74'h0) begin
                    bad++;
                    $display("FAIL idle_tx got=%h required=0", tx);
                end
                if (q.size() > 0 && q[0].due < cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL rsp_missing got none required tid=%h due=%0d", e.tid, e.due);
                end
            end
        end
    end

    task automatic send(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] l,
                        input logic [8:0] t, input logic [63:0] d, input bit resp,
                        input bit chk, input logic [63:0] exp);
        @(posedge clk); #1;
        rx = pk(rd, wr, a, l, t, d);
        if (resp) q.push_back('{tid: t, data: exp, due: cyc + 2, chk: chk});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = '0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (tx !== 74'h0) begin bad++; $display("FAIL rst_tx got=%h required=0", tx); end
        if (ctl !== 64'h0) begin bad++; $display("FAIL rst_ctl got=%h required=0", ctl); end
        if (go !== 1'b0) begin bad++; $display("FAIL rst_go got=%b required=0", go); end
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b required=0", err); end
        mon_en = 1'b1;
        // First read leaves reset together with the release: CYCLES has advanced once.
        @(posedge clk); #1;
        rst = 1'b0;
        rx = pk(1, 0, 16'h0026, 2'd1, 9'h003, 64'h0);
        q.push_back('{tid: 9'h003, data: 64'd1, due: cyc + 2, chk: 1'b1});
        drain();
    endtask

    task automatic test_id();
        send(1, 0, 16'h0000, 2'd1, 9'h015, 64'h0, 1, 1, DFH);
        send(1, 0, 16'h0002, 2'd1, 9'h001, 64'h0, 1, 1, ID_L);
        send(1, 0, 16'h0004, 2'd1, 9'h002, 64'h0, 1, 1, ID_H);
        send(1, 0, 16'h0006, 2'd1, 9'h003, 64'h0, 1, 1, 64'h0);
        send(1, 0, 16'h0005, 2'd0, 9'h004, 64'h0, 1, 1, {32'h0, ID_H[63:32]});
        drain();
    endtask

    task automatic test_scratch();
        send(0, 1, 16'h0020, 2'd1, 9'h000, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'h0);
        send(1, 0, 16'h0020, 2'd1, 9'h010, 64'h0, 1, 1, 64'hDEAD_BEEF_0123_4567);
        send(1, 0, 16'h0021, 2'd0, 9'h011, 64'h0, 1, 1, 64'h0000_0000_DEAD_BEEF);
        send(1, 0, 16'h0020, 2'd0, 9'h012, 64'h0, 1, 1, 64'h0000_0000_0123_4567);
        send(0, 1, 16'h0021, 2'd0, 9'h000, 64'hFFFF_FFFF_1111_2222, 0, 0, 64'h0);
        send(1, 0, 16'h0020, 2'd1, 9'h013, 64'h0, 1, 1, 64'h1111_2222_0123_4567);
        drain();
    endtask

    task automatic test_ctl();
        send(0, 1, 16'h0022, 2'd0, 9'h000, 64'h0000_0000_0000_0005, 0, 0, 64'h0);
        @(negedge clk);
        total++;
        if (go !== 1'b0) begin bad++; $display("FAIL go_early got=%b required=0", go); end
        idle(1);
        @(negedge clk);
        total += 2;
        if (go !== 1'b1) begin bad++; $display("FAIL go_pulse got=%b required=1", go); end
        if (ctl !== 64'h4) begin bad++; $display("FAIL ctl_val got=%h required=4", ctl); end
        idle(1);
        @(negedge clk);
        total++;
        if (go !== 1'b0) begin bad++; $display("FAIL go_clear got=%b required=0", go); end
        send(1, 0, 16'h0022, 2'd1, 9'h020, 64'h0, 1, 1, 64'h4);
        send(0, 1, 16'h0023, 2'd0, 9'h000, 64'h0000_0000_0000_ABCD, 0, 0, 64'h0);
        idle(1);
        @(negedge clk);
        total += 2;
        if (go !== 1'b0) begin bad++; $display("FAIL go_upper got=%b required=0", go); end
        if (ctl !== 64'h0000_ABCD_0000_0004) begin
            bad++; $display("FAIL ctl_upper got=%h required=0000abcd00000004", ctl);
        end
        send(1, 0, 16'h0022, 2'd1, 9'h021, 64'h0, 1, 1, 64'h0000_ABCD_0000_0004);
        drain();
    endtask

    task automatic test_status_cycles();
        status = 64'h5A5A_0000_FFFF_1234;
        cap.delete();
        send(1, 0, 16'h0024, 2'd1, 9'h030, 64'h0, 1, 1, 64'h5A5A_0000_FFFF_1234);
        send(1, 0, 16'h0026, 2'd1, 9'h031, 64'h0, 1, 0, 64'h0);
        idle(4);
        send(1, 0, 16'h0026, 2'd1, 9'h032, 64'h0, 1, 0, 64'h0);
        send(0, 1, 16'h0100, 2'd1, 9'h000, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0);
        send(1, 0, 16'h0100, 2'd1, 9'h033, 64'h0, 1, 1, 64'h0);
`ifndef MMIO_CSR_STATS_EN
        send(0, 1, 16'h0028, 2'd1, 9'h000, 64'h7777, 0, 0, 64'h0);
        send(1, 0, 16'h0028, 2'd1, 9'h034, 64'h0, 1, 1, 64'h0);
`endif
        drain();
        total++;
        if (cap.size() != 2) begin
            bad++; $display("FAIL cycles_cnt got=%0d required=2", cap.size());
        end else if (cap[1] - cap[0] !== 64'd5) begin
            bad++; $display("FAIL cycles_delta got=%0d required=5", cap[1] - cap[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_v [8];
        logic [15:0] adr_v [8];
        for (int i = 0; i < 8; i++) begin
            adr_v[i] = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            exp_v[i] = (i % 2 == 0) ? 64'h1111_2222_0123_4567 : DFH;
        end
        for (int i = 0; i < 8; i++)
            send(1, 0, adr_v[i], 2'd1, 9'(i), 64'h0, 1, 1, exp_v[i]);
        drain();
    endtask

    task automatic test_reset_inflight();
        send(1, 0, 16'h0020, 2'd1, 9'h01A, 64'h0, 0, 0, 64'h0);
        @(posedge clk); #1;
        rx = pk(1, 0, 16'h0020, 2'd1, 9'h01B, 64'h0);
        rst = 1'b1;
        idle(1);
        @(negedge clk);
        total += 3;
        if (tx !== 74'h0) begin bad++; $display("FAIL inflight_tx got=%h required=0", tx); end
        if (ctl !== 64'h0) begin bad++; $display("FAIL inflight_ctl got=%h required=0", ctl); end
        if (err !== 1'b0) begin bad++; $display("FAIL inflight_err got=%b required=0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        send(1, 0, 16'h0020, 2'd1, 9'h01C, 64'h0, 1, 1, 64'h0);
        drain();
    endtask

    task automatic test_err();
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b required=0", err); end
        send(1, 1, 16'h0020, 2'd1, 9'h040, 64'h0000_0000_0000_CAFE, 0, 0, 64'h0);
        idle(1);
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b required=1", err); end
        send(1, 0, 16'h0020, 2'd1, 9'h041, 64'h0, 1, 1, 64'h0000_0000_0000_CAFE);
        send(1, 0, 16'h0021, 2'd1, 9'h042, 64'h0, 1, 1, 64'h0);
        send(0, 1, 16'h0021, 2'd1, 9'h000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0);
        send(1, 0, 16'h0020, 2'd1, 9'h043, 64'h0, 1, 1, 64'h0000_0000_0000_CAFE);
        send(1, 0, 16'h0020, 2'd2, 9'h044, 64'h0, 1, 1, 64'h0);
        drain();
        idle(5);
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required=1", err); end
    endtask

`ifdef MMIO_CSR_STATS_EN
    task automatic test_stats();
        send(0, 1, 16'h002C, 2'd1, 9'h000, 64'h0, 0, 0, 64'h0);
        send(1, 0, 16'h0020, 2'd1, 9'h050, 64'h0, 1, 1, 64'h0000_0000_0000_CAFE);
        send(1, 0, 16'h0020, 2'd1, 9'h051, 64'h0, 1, 1, 64'h0000_0000_0000_CAFE);
        send(0, 1, 16'h0020, 2'd1, 9'h000, 64'h1, 0, 0, 64'h0);
        send(0, 1, 16'h0020, 2'd1, 9'h000, 64'h2, 0, 0, 64'h0);
        send(1, 0, 16'h0028, 2'd1, 9'h052, 64'h0, 1, 1, 64'd3);
        send(1, 0, 16'h002A, 2'd1, 9'h053, 64'h0, 1, 1, 64'd2);
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_id();
        test_scratch();
        test_ctl();
        test_status_cycles();
        test_back_to_back();
        test_reset_inflight();
        test_err();
`ifdef MMIO_CSR_STATS_EN
        test_stats();
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
